// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: CPU-side interrupt receiver. Captures rising edges on the
// request lines, arbitrates by fixed priority (highest index wins) against the
// currently running level, and redirects the CPU at instruction boundaries.
// Supports nesting up to NUM_IRQ levels, with one saved return PC per level.
module interrupt_ctrl #(
   parameter int          NUM_IRQ    = 3,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0040
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               int_en,
   input  logic               insn_boundary,
   input  logic [31:0]        pc_next,
   input  logic               eret,
   output logic               take,
   output logic [31:0]        vector,
   output logic [31:0]        epc,
   output logic [NUM_IRQ-1:0] running,
   output logic [NUM_IRQ-1:0] pending
);

   localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   logic [NUM_IRQ-1:0] irq_d_q;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] running_q, running_d;
   logic               take_q, take_d;
   logic [31:0]        vector_q, vector_d;
   logic [31:0]        epc_slot_q [NUM_IRQ];
   logic [31:0]        epc_slot_d [NUM_IRQ];

   logic [NUM_IRQ-1:0] irq_edge;
   logic               ceil_vld;
   logic [IW-1:0]      ceil_idx;
   logic               cand_vld;
   logic [IW-1:0]      cand_idx;
   logic               take_dec;
   logic               eret_do;

   // Ceiling: highest running level; nothing running means any pending line may preempt.
   always_comb begin
      ceil_vld = 1'b0;
      ceil_idx = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (running_q[i]) begin
            ceil_vld = 1'b1;
            ceil_idx = IW'(i);
         end
      end
   end

   // Candidate: highest-index pending line strictly above the ceiling.
   always_comb begin
      cand_vld = 1'b0;
      cand_idx = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (pending_q[i] && (!ceil_vld || (i > int'(ceil_idx)))) begin
            cand_vld = 1'b1;
            cand_idx = IW'(i);
         end
      end
   end

   // Next-state: eret beats take, and a fresh edge beats the pending clear on take.
   always_comb begin
      irq_edge   = irq_in & ~irq_d_q;
      eret_do    = eret & ceil_vld;
      take_dec   = insn_boundary & int_en & ~eret & ~take_q & cand_vld;
      pending_d  = pending_q;
      running_d  = running_q;
      take_d     = take_dec;
      vector_d   = vector_q;
      epc_slot_d = epc_slot_q;
      if (take_dec) begin
         pending_d[cand_idx]  = 1'b0;
         running_d[cand_idx]  = 1'b1;
         vector_d             = VEC_BASE + (32'(cand_idx) * VEC_STRIDE);
         epc_slot_d[cand_idx] = pc_next;
      end
      if (eret_do) begin
         running_d[ceil_idx] = 1'b0;
      end
      pending_d = pending_d | irq_edge;
   end

   // State registers; reset clears everything, including requests in flight.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         irq_d_q   <= '0;
         pending_q <= '0;
         running_q <= '0;
         take_q    <= 1'b0;
         vector_q  <= VEC_BASE;
         for (int i = 0; i < NUM_IRQ; i++) begin
            epc_slot_q[i] <= '0;
         end
      end else begin
         irq_d_q   <= irq_in;
         pending_q <= pending_d;
         running_q <= running_d;
         take_q    <= take_d;
         vector_q  <= vector_d;
         for (int i = 0; i < NUM_IRQ; i++) begin
            epc_slot_q[i] <= epc_slot_d[i];
         end
      end
   end

   assign take    = take_q;
   assign vector  = vector_q;
   assign running = running_q;
   assign pending = pending_q;
   assign epc     = ceil_vld ? epc_slot_q[ceil_idx] : 32'h0;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed testbench for interrupt_ctrl: one task per scenario, inline checks.
module tb_interrupt_ctrl;

   logic        clk;
   logic        clr;
   logic [2:0]  irq_in;
   logic        int_en;
   logic        insn_boundary;
   logic [31:0] pc_next;
   logic        eret;
   logic        take;
   logic [31:0] vector;
   logic [31:0] epc;
   logic [2:0]  running;
   logic [2:0]  pending;

   int tests = 0;
   int fails = 0;

   interrupt_ctrl #(
      .NUM_IRQ(3),
      .VEC_BASE(32'h0000_0100),
      .VEC_STRIDE(32'h0000_0040)
   ) dut (
      .clk(clk),
      .clr(clr),
      .irq_in(irq_in),
      .int_en(int_en),
      .insn_boundary(insn_boundary),
      .pc_next(pc_next),
      .eret(eret),
      .take(take),
      .vector(vector),
      .epc(epc),
      .running(running),
      .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr = 1'b0; irq_in = 3'b000; int_en = 1'b1; insn_boundary = 1'b1;
      pc_next = 32'h0; eret = 1'b0;
      #12;
      clr = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         tests++; if (take !== 1'b0) begin fails++; $display("FAIL reset_take: got %0b want 0", take); end
         tests++; if (running !== 3'b000) begin fails++; $display("FAIL reset_running: got %b want 000", running); end
         tests++; if (pending !== 3'b000) begin fails++; $display("FAIL reset_pending: got %b want 000", pending); end
         tests++; if (epc !== 32'h0) begin fails++; $display("FAIL reset_epc: got %h want 0", epc); end
         tests++; if (vector !== 32'h100) begin fails++; $display("FAIL reset_vector: got %h want 100", vector); end
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_single();
      irq_in = 3'b001; pc_next = 32'h20;
      tick();
      tests++; if (pending !== 3'b001) begin fails++; $display("FAIL single_pending: got %b want 001", pending); end
      tests++; if (take !== 1'b0) begin fails++; $display("FAIL single_early_take: got %0b want 0", take); end
      tick();
      irq_in = 3'b000;
      tests++; if (take !== 1'b1) begin fails++; $display("FAIL single_take: got %0b want 1", take); end
      tests++; if (vector !== 32'h100) begin fails++; $display("FAIL single_vector: got %h want 100", vector); end
      tests++; if (running !== 3'b001) begin fails++; $display("FAIL single_running: got %b want 001", running); end
      tests++; if (epc !== 32'h20) begin fails++; $display("FAIL single_epc: got %h want 20", epc); end
      tests++; if (pending !== 3'b000) begin fails++; $display("FAIL single_pending_clr: got %b want 000", pending); end
      tick();
      tests++; if (take !== 1'b0) begin fails++; $display("FAIL single_one_pulse: got %0b want 0", take); end
      eret = 1'b1;
      tick();
      eret = 1'b0;
      tests++; if (running !== 3'b000) begin fails++; $display("FAIL single_eret_running: got %b want 000", running); end
      tests++; if (epc !== 32'h0) begin fails++; $display("FAIL single_eret_epc: got %h want 0", epc); end
      $display("[TB] test_single done");
   endtask

   task automatic test_priority();
      irq_in = 3'b101;
      tick();
      irq_in = 3'b000;
      tests++; if (pending !== 3'b101) begin fails++; $display("FAIL prio_pending: got %b want 101", pending); end
      tick();
      tests++; if (take !== 1'b1) begin fails++; $display("FAIL prio_take: got %0b want 1", take); end
      tests++; if (vector !== 32'h180) begin fails++; $display("FAIL prio_vector: got %h want 180", vector); end
      tests++; if (running !== 3'b100) begin fails++; $display("FAIL prio_running: got %b want 100", running); end
      tests++; if (pending !== 3'b001) begin fails++; $display("FAIL prio_pending_left: got %b want 001", pending); end
      tick();
      tick();
      tests++; if (take !== 1'b0) begin fails++; $display("FAIL prio_no_preempt: got %0b want 0", take); end
      eret = 1'b1;
      tick();
      eret = 1'b0;
      tests++; if (take !== 1'b0) begin fails++; $display("FAIL prio_eret_cycle: got %0b want 0", take); end
      tests++; if (running !== 3'b000) begin fails++; $display("FAIL prio_eret_running: got %b want 000", running); end
      tick();
      tests++; if (take !== 1'b1) begin fails++; $display("FAIL prio_second_take: got %0b want 1", take); end
      tests++; if (vector !== 32'h100) begin fails++; $display("FAIL prio_second_vector: got %h want 100", vector); end
      eret = 1'b1;
      tick();
      eret = 1'b0;
      tests++; if (running !== 3'b000) begin fails++; $display("FAIL prio_cleanup: got %b want 000", running); end
      $display("[TB] test_priority done");
   endtask

   task automatic test_nesting();
      irq_in = 3'b001; pc_next = 32'h40;
      tick();
      irq_in = 3'b000;
      tick();
      tests++; if (running !== 3'b001) begin fails++; $display("FAIL nest_first_running: got %b want 001", running); end
      tests++; if (epc !== 32'h40) begin fails++; $display("FAIL nest_first_epc: got %h want 40", epc); end
      irq_in = 3'b010; pc_next = 32'h104;
      tick();
      irq_in = 3'b000;
      tick();
      tests++; if (take !== 1'b1) begin fails++; $display("FAIL nest_take: got %0b want 1", take); end
      tests++; if (vector !== 32'h140) begin fails++; $display("FAIL nest_vector: got %h want 140", vector); end
      tests++; if (running !== 3'b011) begin fails++; $display("FAIL nest_running: got %b want 011", running); end
      tests++; if (epc !== 32'h104) begin fails++; $display("FAIL nest_epc: got %h want 104", epc); end
      eret = 1'b1;
      tick();
      eret = 1'b0;
      tests++; if (running !== 3'b001) begin fails++; $display("FAIL nest_eret_running: got %b want 001", running); end
      tests++; if (epc !== 32'h40) begin fails++; $display("FAIL nest_eret_epc: got %h want 40", epc); end
      eret = 1'b1;
      tick();
      eret = 1'b0;
      tests++; if (running !== 3'b000) begin fails++; $display("FAIL nest_cleanup: got %b want 000", running); end
      $display("[TB] test_nesting done");
   endtask

   task automatic test_masked();
      irq_in = 3'b100;
      tick();
      irq_in = 3'b000;
      tick();
      tests++; if (running !== 3'b100) begin fails++; $display("FAIL mask_running: got %b want 100", running); end
      irq_in = 3'b010;
      tick();
      irq_in = 3'b000;
      for (int c = 0; c < 3; c++) begin
         tick();
         tests++; if (take !== 1'b0) begin fails++; $display("FAIL mask_no_take: got %0b want 0", take); end
         tests++; if (pending !== 3'b010) begin fails++; $display("FAIL mask_pending: got %b want 010", pending); end
      end
      eret = 1'b1;
      tick();
      eret = 1'b0;
      tests++; if (take !== 1'b0) begin fails++; $display("FAIL mask_eret_take: got %0b want 0", take); end
      tick();
      tests++; if (take !== 1'b1) begin fails++; $display("FAIL mask_late_take: got %0b want 1", take); end
      tests++; if (vector !== 32'h140) begin fails++; $display("FAIL mask_late_vector: got %h want 140", vector); end
      tests++; if (running !== 3'b010) begin fails++; $display("FAIL mask_late_running: got %b want 010", running); end
      eret = 1'b1;
      tick();
      eret = 1'b0;
      $display("[TB] test_masked done");
   endtask

   task automatic test_int_en();
      int_en = 1'b0; irq_in = 3'b100;
      tick();
      irq_in = 3'b000;
      for (int c = 0; c < 3; c++) begin
         tick();
         tests++; if (take !== 1'b0) begin fails++; $display("FAIL inten_no_take: got %0b want 0", take); end
         tests++; if (pending !== 3'b100) begin fails++; $display("FAIL inten_pending: got %b want 100", pending); end
      end
      int_en = 1'b1; insn_boundary = 1'b0;
      tick();
      tests++; if (take !== 1'b0) begin fails++; $display("FAIL inten_no_boundary: got %0b want 0", take); end
      insn_boundary = 1'b1;
      tick();
      tests++; if (take !== 1'b1) begin fails++; $display("FAIL inten_take: got %0b want 1", take); end
      tests++; if (vector !== 32'h180) begin fails++; $display("FAIL inten_vector: got %h want 180", vector); end
      eret = 1'b1;
      tick();
      eret = 1'b0;
      $display("[TB] test_int_en done");
   endtask

   task automatic test_eret_candidate();
      irq_in = 3'b001; pc_next = 32'h60;
      tick();
      irq_in = 3'b000;
      tick();
      tests++; if (running !== 3'b001) begin fails++; $display("FAIL ec_running: got %b want 001", running); end
      int_en = 1'b0; irq_in = 3'b100;
      tick();
      irq_in = 3'b000;
      int_en = 1'b1; eret = 1'b1;
      tick();
      eret = 1'b0;
      tests++; if (take !== 1'b0) begin fails++; $display("FAIL ec_take_in_eret: got %0b want 0", take); end
      tests++; if (running !== 3'b000) begin fails++; $display("FAIL ec_eret_running: got %b want 000", running); end
      tests++; if (pending !== 3'b100) begin fails++; $display("FAIL ec_pending: got %b want 100", pending); end
      tick();
      tests++; if (take !== 1'b1) begin fails++; $display("FAIL ec_retake: got %0b want 1", take); end
      tests++; if (vector !== 32'h180) begin fails++; $display("FAIL ec_vector: got %h want 180", vector); end
      eret = 1'b1;
      tick();
      eret = 1'b0;
      // eret with nothing running must be ignored
      int_en = 1'b0; irq_in = 3'b010;
      tick();
      irq_in = 3'b000; eret = 1'b1;
      tick();
      eret = 1'b0;
      tests++; if (running !== 3'b000) begin fails++; $display("FAIL ec_idle_eret_running: got %b want 000", running); end
      tests++; if (pending !== 3'b010) begin fails++; $display("FAIL ec_idle_eret_pending: got %b want 010", pending); end
      int_en = 1'b1;
      tick();
      tests++; if (vector !== 32'h140) begin fails++; $display("FAIL ec_idle_vector: got %h want 140", vector); end
      $display("[TB] test_eret_candidate done");
   endtask

   task automatic test_reset_mid();
      // line 1 is running from the previous task; add a pending request too
      int_en = 1'b0; irq_in = 3'b001;
      tick();
      irq_in = 3'b000;
      tests++; if (running !== 3'b010) begin fails++; $display("FAIL rm_pre_running: got %b want 010", running); end
      #2;
      clr = 1'b0;
      #1;
      tests++; if (take !== 1'b0) begin fails++; $display("FAIL rm_take: got %0b want 0", take); end
      tests++; if (running !== 3'b000) begin fails++; $display("FAIL rm_running: got %b want 000", running); end
      tests++; if (pending !== 3'b000) begin fails++; $display("FAIL rm_pending: got %b want 000", pending); end
      tests++; if (epc !== 32'h0) begin fails++; $display("FAIL rm_epc: got %h want 0", epc); end
      tests++; if (vector !== 32'h100) begin fails++; $display("FAIL rm_vector: got %h want 100", vector); end
      tick();
      clr = 1'b1; int_en = 1'b1;
      tick();
      tick();
      tests++; if (take !== 1'b0) begin fails++; $display("FAIL rm_after_take: got %0b want 0", take); end
      $display("[TB] test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_nesting();
      test_masked();
      test_int_en();
      test_eret_candidate();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
